// File: rtl/simon_pkg.sv
// Shared Simon game definitions: color encoding, sequencer FSM states and LFSR width.
package simon_pkg;

  typedef logic [1:0] color_t;

  localparam color_t COLOR_B = 2'b00;
  localparam color_t COLOR_G = 2'b01;
  localparam color_t COLOR_R = 2'b10;
  localparam color_t COLOR_Y = 2'b11;

  localparam int unsigned LFSR_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  // Maps two random bits onto a named color.
  function automatic color_t to_color(input logic [1:0] bits);
    color_t c;
    unique case (bits)
      2'b00:   c = COLOR_B;
      2'b01:   c = COLOR_G;
      2'b10:   c = COLOR_R;
      default: c = COLOR_Y;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/simon_lfsr.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) with synchronous seed load.
module simon_lfsr
  import simon_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign state = lfsr_q;

endmodule

// File: rtl/simon_sequence_player.sv
// Stores the Simon color sequence, appends random colors and plays it back as timed color/go pulses.
module simon_sequence_player
  import simon_pkg::*;
#(
  parameter  int unsigned MAX_LEN   = 32,
  parameter  int unsigned ON_TICKS  = 25_000_000,
  parameter  int unsigned OFF_TICKS = 12_500_000,
  localparam int unsigned LW        = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          append,
  input  logic          start,
  input  logic [LW-1:0] rd_idx,
  output logic [1:0]    rd_color,
  output logic [1:0]    color,
  output logic          go,
  output logic          busy,
  output logic          done,
  output logic [LW-1:0] length,
  output logic          full
);

  localparam int unsigned AW       = $clog2(MAX_LEN);
  localparam int unsigned TICK_MAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int unsigned TW       = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;

  localparam logic [TW-1:0] ON_RELOAD  = TW'(ON_TICKS - 1);
  localparam logic [TW-1:0] OFF_RELOAD = TW'(OFF_TICKS - 1);
  localparam logic [LW-1:0] LEN_MAX    = LW'(MAX_LEN);

  logic [LFSR_W-1:0] lfsr_state;
  logic              unused_lfsr;
  color_t            new_color;
  logic              wr_en;

  state_t            state_q,  state_d;
  logic [AW-1:0]     idx_q,    idx_d;
  logic [TW-1:0]     timer_q,  timer_d;
  logic [LW-1:0]     length_q, length_d;
  logic              full_q,   full_d;
  color_t            color_q,  color_d;
  logic              go_q,     go_d;
  logic              busy_q,   busy_d;
  logic              done_q,   done_d;

  color_t            mem_q [MAX_LEN];

  simon_lfsr #(
    .SEED (16'hACE1)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .state (lfsr_state)
  );

  assign new_color   = to_color(lfsr_state[1:0]);
  assign unused_lfsr = ^lfsr_state[LFSR_W-1:2];

  // Next-state, sequence bookkeeping and registered output values.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    timer_d  = timer_q;
    length_d = length_q;
    done_d   = 1'b0;
    wr_en    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (clear) begin
          length_d = '0;
        end else if (append) begin
          if (!full_q) begin
            wr_en    = 1'b1;
            length_d = length_q + LW'(1);
          end
        end else if (start) begin
          if (length_q != '0) begin
            state_d = ST_ON;
            idx_d   = '0;
            timer_d = ON_RELOAD;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_ON: begin
        if (clear) begin
          state_d  = ST_IDLE;
          length_d = '0;
        end else if (timer_q == '0) begin
          state_d = ST_OFF;
          timer_d = OFF_RELOAD;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      ST_OFF: begin
        if (clear) begin
          state_d  = ST_IDLE;
          length_d = '0;
        end else if (timer_q == '0) begin
          if (LW'(idx_q) == length_q - LW'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_ON;
            idx_d   = idx_q + AW'(1);
            timer_d = ON_RELOAD;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    full_d  = (length_d == LEN_MAX);
    go_d    = (state_d == ST_ON);
    busy_d  = (state_d != ST_IDLE);
    color_d = (state_d == ST_ON) ? mem_q[idx_d] : color_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      timer_q  <= '0;
      length_q <= '0;
      full_q   <= 1'b0;
      color_q  <= COLOR_B;
      go_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      timer_q  <= timer_d;
      length_q <= length_d;
      full_q   <= full_d;
      color_q  <= color_d;
      go_q     <= go_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Sequence storage has no reset; only entries below length are ever observed.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[AW'(length_q)] <= new_color;
  end

  assign rd_color = (rd_idx < length_q) ? mem_q[AW'(rd_idx)] : COLOR_B;
  assign color    = color_q;
  assign go       = go_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign length   = length_q;
  assign full     = full_q;

endmodule

// File: tb/tb_simon_sequence_player.sv
// Directed bench for simon_sequence_player with short tick counts and a 4-entry sequence.
module tb_simon_sequence_player;

  localparam int unsigned MAX_LEN   = 4;
  localparam int unsigned ON_TICKS  = 4;
  localparam int unsigned OFF_TICKS = 2;
  localparam int unsigned LW        = 3;

  logic          clk;
  logic          reset;
  logic          clear;
  logic          append;
  logic          start;
  logic [LW-1:0] rd_idx;
  logic [1:0]    rd_color;
  logic [1:0]    color;
  logic          go;
  logic          busy;
  logic          done;
  logic [LW-1:0] length;
  logic          full;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] m_lfsr;
  logic [1:0]  exp_mem [MAX_LEN];

  typedef struct {
    logic go;
    logic busy;
    logic done;
    int   ent;
  } play_vec_t;

  play_vec_t pv [20];

  simon_sequence_player #(
    .MAX_LEN   (MAX_LEN),
    .ON_TICKS  (ON_TICKS),
    .OFF_TICKS (OFF_TICKS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .append   (append),
    .start    (start),
    .rd_idx   (rd_idx),
    .rd_color (rd_color),
    .color    (color),
    .go       (go),
    .busy     (busy),
    .done     (done),
    .length   (length),
    .full     (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR: feedback is the XOR of tap positions 16,14,13,11 shifted in at the bottom.
  function automatic logic [15:0] model_step(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return (s << 1) | {15'd0, fb};
  endfunction

  always @(posedge clk) begin
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= model_step(m_lfsr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag, input logic [LW-1:0] exp_len, input logic exp_done);
    chk({tag, " go"},     32'(go),     32'(0));
    chk({tag, " busy"},   32'(busy),   32'(0));
    chk({tag, " done"},   32'(done),   32'(exp_done));
    chk({tag, " length"}, 32'(length), 32'(exp_len));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pv = '{
      '{1'b1, 1'b1, 1'b0, 0}, '{1'b1, 1'b1, 1'b0, 0}, '{1'b1, 1'b1, 1'b0, 0}, '{1'b1, 1'b1, 1'b0, 0},
      '{1'b0, 1'b1, 1'b0, 0}, '{1'b0, 1'b1, 1'b0, 0},
      '{1'b1, 1'b1, 1'b0, 1}, '{1'b1, 1'b1, 1'b0, 1}, '{1'b1, 1'b1, 1'b0, 1}, '{1'b1, 1'b1, 1'b0, 1},
      '{1'b0, 1'b1, 1'b0, 1}, '{1'b0, 1'b1, 1'b0, 1},
      '{1'b1, 1'b1, 1'b0, 2}, '{1'b1, 1'b1, 1'b0, 2}, '{1'b1, 1'b1, 1'b0, 2}, '{1'b1, 1'b1, 1'b0, 2},
      '{1'b0, 1'b1, 1'b0, 2}, '{1'b0, 1'b1, 1'b0, 2},
      '{1'b0, 1'b0, 1'b1, 2},
      '{1'b0, 1'b0, 1'b0, 2}
    };

    reset  = 1'b1;
    clear  = 1'b0;
    append = 1'b0;
    start  = 1'b0;
    rd_idx = '0;
    repeat (3) cyc();
    reset = 1'b0;

    chk("reset color", 32'(color), 32'(0));
    chk("reset full",  32'(full),  32'(0));
    check_idle("reset", 3'd0, 1'b0);

    // Three appends, two cycles apart; each stores the LFSR value present at the append edge.
    for (int i = 0; i < 3; i++) begin
      exp_mem[i] = m_lfsr[1:0];
      append = 1'b1;
      cyc();
      append = 1'b0;
      rd_idx = LW'(i);
      #1;
      chk("append length", 32'(length), 32'(i + 1));
      chk("append rd_color", 32'(rd_color), 32'(exp_mem[i]));
      cyc();
    end
    for (int i = 0; i < 3; i++) begin
      rd_idx = LW'(i);
      #1;
      chk("readback rd_color", 32'(rd_color), 32'(exp_mem[i]));
    end
    rd_idx = 3'd3;
    #1;
    chk("rd_color beyond length", 32'(rd_color), 32'(0));

    // Playback of three entries, compared cycle by cycle against the table.
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      chk($sformatf("play go c%0d", c),    32'(go),    32'(pv[c].go));
      chk($sformatf("play busy c%0d", c),  32'(busy),  32'(pv[c].busy));
      chk($sformatf("play done c%0d", c),  32'(done),  32'(pv[c].done));
      chk($sformatf("play color c%0d", c), 32'(color), 32'(exp_mem[pv[c].ent]));
      cyc();
    end
    chk("play length kept", 32'(length), 32'(3));

    // Start on an empty sequence: immediate done, no playback.
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    check_idle("clear", 3'd0, 1'b0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    check_idle("empty start", 3'd0, 1'b1);
    cyc();
    check_idle("empty start after", 3'd0, 1'b0);

    // Six appends into a 4-entry store: saturates at full.
    for (int i = 0; i < 6; i++) begin
      if (i < int'(MAX_LEN)) exp_mem[i] = m_lfsr[1:0];
      append = 1'b1;
      cyc();
      append = 1'b0;
      chk("fill length", 32'(length), 32'((i < 4) ? i + 1 : 4));
      chk("fill full",   32'(full),   32'((i >= 3) ? 1 : 0));
      cyc();
    end
    for (int i = 0; i < 4; i++) begin
      rd_idx = LW'(i);
      #1;
      chk("full rd_color", 32'(rd_color), 32'(exp_mem[i]));
    end
    rd_idx = 3'd4;
    #1;
    chk("rd_color at length", 32'(rd_color), 32'(0));

    // Clear during the second ON phase aborts playback.
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (6) cyc();
    chk("abort pre go",    32'(go),    32'(1));
    chk("abort pre color", 32'(color), 32'(exp_mem[1]));
    cyc();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    check_idle("abort", 3'd0, 1'b0);
    chk("abort full", 32'(full), 32'(0));
    for (int c = 0; c < 3; c++) begin
      cyc();
      check_idle("abort after", 3'd0, 1'b0);
    end

    // Simultaneous clear/append/start in IDLE: clear wins, nothing else happens.
    append = 1'b1;
    cyc();
    append = 1'b0;
    chk("prio setup length", 32'(length), 32'(1));
    clear  = 1'b1;
    append = 1'b1;
    start  = 1'b1;
    cyc();
    clear  = 1'b0;
    append = 1'b0;
    start  = 1'b0;
    check_idle("prio", 3'd0, 1'b0);
    for (int c = 0; c < 8; c++) begin
      cyc();
      check_idle("prio after", 3'd0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/simon_sequence_player.md
# simon_sequence_player

Upstream stage of `show_color` in the Simon game datapath. It stores the growing random color sequence, appends one pseudo-random color per round, and on request plays the sequence back as timed `color`/`go` pulses that drive `show_color` directly. It also exposes a combinational read port so the player-input checker can compare presses against the stored sequence.

## Interface
- `MAX_LEN`, 32: sequence capacity in entries (≥2).
- `ON_TICKS`, 25_000_000: cycles each color is shown (`go` high), ≥1.
- `OFF_TICKS`, 12_500_000: blank cycles after each color (`go` low), ≥1.
- `LW` (localparam) = $clog2(MAX_LEN+1).

Ports (clock first; reset is synchronous, active-high, as decided):
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous active-high reset.
- `clear`  in  1  empties the sequence.
- `append`  in  1  single-cycle request to append one random color.
- `start`  in  1  single-cycle request to begin playback.
- `rd_idx`  in  LW  read index for the checker.
- `rd_color`  out  2  `mem[rd_idx]`, combinational; 2'b00 if `rd_idx` ≥ `length`.
- `color`  out  2  color to `show_color`.
- `go`  out  1  show-enable to `show_color`.
- `busy`  out  1  high during playback.
- `done`  out  1  one-cycle pulse at end of playback.
- `length`  out  LW  number of stored entries.
- `full`  out  1  `length == MAX_LEN`.

## Operation
- Color encoding B=00, G=01, R=10, Y=11.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1 on reset, advances every cycle unconditionally. New color = `lfsr[1:0]`.
- FSM states: IDLE, ON, OFF.
- IDLE: `go`=0, `busy`=0.
  - `clear` → `length`←0.
  - Else `append` with `!full` → `mem[length]`←`lfsr[1:0]`, `length`+1.
  - Else `start` with `length`>0 → ON, `idx`←0, timer←ON_TICKS-1.
  - `start` with `length`==0 → stay IDLE, `done` pulses next cycle.
  - Priority when simultaneous: `clear` > `append` > `start`. Lower-priority requests in the same cycle are dropped.
- ON: `go`=1, `color`=`mem[idx]`, `busy`=1. Timer decrements. When timer==0 → OFF, timer←OFF_TICKS-1.
- OFF: `go`=0, `color` holds last value, `busy`=1. When timer==0:
  - if `idx`==`length`-1 → IDLE, `done`=1 for one cycle;
  - else `idx`+1 → ON, timer←ON_TICKS-1.
- While busy, `append` and `start` are ignored.
- `clear` while busy aborts: next state IDLE, `go`=0, `length`=0, no `done`.
- `append` when full is ignored; `length` saturates at MAX_LEN.
- Reset values: `color`=00, `go`=0, `busy`=0, `done`=0, `length`=0, `full`=0, state IDLE, `idx`=0, timer=0, memory contents don't-care.

## Timing
- All outputs except `rd_color` are registered.
- `start` sampled at edge k: `go`/`busy` are high from edge k+1.
- Each entry: `go` high exactly ON_TICKS cycles, then low exactly OFF_TICKS cycles.
- N entries: `busy` high for N·(ON_TICKS+OFF_TICKS) cycles. `done` is high in the first cycle after `busy` falls, coincident with the return to IDLE.
- `append` at edge k: `length` and `mem` are updated at edge k+1; `rd_color` for the new entry is valid in that same cycle.

## Structure
- Shared package `simon_pkg`: color constants B/G/R/Y, `color_t` (2-bit), FSM state enum. `show_color` and the checker use the same package.
- Sub-module `simon_lfsr`: 16-bit LFSR with synchronous reset and seed parameter, outputs full state. Everything else (FSM, timer, memory) lives in the top module.

## Test plan
Bench uses ON_TICKS=4, OFF_TICKS=2, MAX_LEN=4.
- Reset, then 3 `append` pulses 2 cycles apart → `length`=3; `rd_color` at idx 0..2 matches the bench LFSR model's `lfsr[1:0]` (seed ACE1) at each append cycle.
- `start` with 3 entries → `go` pattern 4 high / 2 low repeated 3×; `color` equals `mem[0..2]`; `busy` high 18 cycles; `done` a single pulse in cycle 19.
- `start` with `length`=0 → `go` never rises, `busy` stays 0, `done` pulses the next cycle.
- 6 `append` pulses → `length`=4, `full`=1, entries 0..3 unchanged by the extra requests.
- `clear` asserted during the 2nd ON phase → next cycle `go`=0, `busy`=0, `length`=0, no `done`.
- `clear`, `append` and `start` in the same IDLE cycle → `length`=0, no playback, no `done`.
